// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor built around one full-adder cell. Operands are
// captured on a start request and then consumed one bit per clock, LSB first.
// A single carry flip-flop links the bit slices. The result bits are
// assembled in a shift register and published as one word when the operation
// completes.
//
// Add mode (sub=0) computes a + b + cin. Subtract mode (sub=1) computes
// a + ~b + 1, which is a - b. In subtract mode cout=1 means no borrow
// occurred.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; overrides all other inputs
//   start     in   operation request, sampled only while idle
//   sub       in   mode select, captured with start (0 = add, 1 = subtract)
//   a, b      in   WIDTH-bit operands, captured with start
//   cin       in   carry-in for add mode, captured with start
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse; sum/cout/overflow are valid during it
//   sum       out  WIDTH-bit result, held until the next completion
//   cout      out  carry out of the MSB
//   overflow  out  signed overflow (carry into MSB xor carry out of MSB)
//
// Timing: when start is accepted on edge k, done is high in the cycle after
// edge k+WIDTH. Back-to-back operations therefore issue every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;        // operand A, shifted right once per bit
    logic [WIDTH-1:0] opb;        // operand B (already inverted for subtract)
    logic [WIDTH-1:0] res;        // partial result, filled from the MSB end
    logic             carry;      // carry into the bit currently processed
    logic [CNT_W-1:0] cnt;        // index of the bit currently processed

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] s_msb;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // The full-adder cell, operating on the current LSBs and the carry.
    // The new sum bit is placed in the MSB of the result register so that
    // after WIDTH right shifts the first (LSB) result bit has landed at bit 0.
    // Building s_msb by bit assignment keeps this legal for WIDTH=1.
    always_comb begin
        bit_s              = opa[0] ^ opb[0] ^ carry;
        bit_c              = maj3(opa[0], opb[0], carry);
        s_msb              = '0;
        s_msb[WIDTH-1]     = bit_s;
        res_next           = (res >> 1) | s_msb;
        last_bit           = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the
                        // carry with 1, ignoring cin.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= bit_c;
                    res   <= res_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // On the MSB slice, the carry register still holds
                        // the carry into the MSB, and bit_c is the carry out.
                        sum      <= res_next;
                        cout     <= bit_c;
                        overflow <= carry ^ bit_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; a request still
                    // held high is picked up on the following IDLE cycle.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start1 = 1'b0, sub1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       busy1, done1, sum1, cout1, ovf1;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .overflow(ovf1)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .overflow(ovf8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
        .overflow(ovf16)
    );

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t v8[8];
    vec_t v1[8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic [15:0] es, input logic ec,
                                input logic eo);
        vec_t v;
        v.s = s; v.a = a; v.b = b; v.c = c; v.es = es; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    task automatic drive(input int w, input logic st, input logic s, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        case (w)
            1: begin start1 = st; sub1 = s; a1 = a[0]; b1 = b[0]; cin1 = c; end
            8: begin start8 = st; sub8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = c; end
            default: begin start16 = st; sub16 = s; a16 = a; b16 = b; cin16 = c; end
        endcase
    endtask

    function automatic logic busy_of(input int w);
        return (w == 1) ? busy1 : (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 1) ? done1 : (w == 8) ? done8 : done16;
    endfunction
    function automatic logic cout_of(input int w);
        return (w == 1) ? cout1 : (w == 8) ? cout8 : cout16;
    endfunction
    function automatic logic ovf_of(input int w);
        return (w == 1) ? ovf1 : (w == 8) ? ovf8 : ovf16;
    endfunction
    function automatic logic [15:0] sum_of(input int w);
        return (w == 1) ? {15'd0, sum1} : (w == 8) ? {8'd0, sum8} : sum16;
    endfunction

    // Steps clock by clock until done; counts sampled cycles, busy cycles and
    // any change of sum before done.
    task automatic wait_done(input int w, input int limit, input logic [15:0] pre,
                             output int n, output int nb, output int holdbad, output bit got);
        n = 0; nb = 0; holdbad = 0; got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            n++;
            if (done_of(w)) begin
                got = 1'b1;
                break;
            end
            if (busy_of(w)) nb++;
            if (sum_of(w) !== pre) holdbad++;
        end
    endtask

    // Issues one operation; n counts sampled cycles starting at the accepting
    // edge, so done should be seen at n == WIDTH+1.
    task automatic run_op(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic c, output logic [15:0] rs, output logic rc, output logic ro,
                          output int n, output int nb, output int holdbad, output bit got);
        logic [15:0] pre;
        int n2, nb2, hb2;
        pre = sum_of(w);
        @(posedge clk); #1;
        drive(w, 1'b1, s, a, b, c);
        @(posedge clk); #1;
        n  = 1;
        nb = busy_of(w) ? 1 : 0;
        holdbad = (sum_of(w) !== pre) ? 1 : 0;
        // Scramble inputs after capture; the operation must not notice.
        drive(w, 1'b0, ~s, ~a, ~b, ~c);
        wait_done(w, 40, pre, n2, nb2, hb2, got);
        n += n2; nb += nb2; holdbad += hb2;
        rs = sum_of(w); rc = cout_of(w); ro = ovf_of(w);
    endtask

    initial begin
        logic [15:0] rs;
        logic rc, ro;
        int n, nb, hb, dseen;
        bit got;
        int widths[3];
        widths = '{1, 8, 16};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        foreach (widths[k]) begin
            check($sformatf("reset_busy_w%0d", widths[k]), busy_of(widths[k]), 0);
            check($sformatf("reset_done_w%0d", widths[k]), done_of(widths[k]), 0);
            check($sformatf("reset_sum_w%0d", widths[k]), sum_of(widths[k]), 0);
            check($sformatf("reset_cout_w%0d", widths[k]), cout_of(widths[k]), 0);
            check($sformatf("reset_ovf_w%0d", widths[k]), ovf_of(widths[k]), 0);
        end
        rst = 1'b0;

        // ---------------- WIDTH=8 directed table ----------------
        v8[0] = mk(0, 16'h3C, 16'h5A, 0, 16'h96, 0, 1);
        v8[1] = mk(0, 16'hFF, 16'h01, 1, 16'h01, 1, 0);
        v8[2] = mk(1, 16'h05, 16'h07, 0, 16'hFE, 0, 0);
        v8[3] = mk(1, 16'h80, 16'h01, 0, 16'h7F, 1, 1);
        v8[4] = mk(0, 16'h7F, 16'h01, 0, 16'h80, 0, 1);
        v8[5] = mk(1, 16'h00, 16'h00, 1, 16'h00, 1, 0);
        v8[6] = mk(0, 16'h80, 16'h80, 0, 16'h00, 1, 1);
        v8[7] = mk(1, 16'h7F, 16'hFF, 0, 16'h80, 0, 1);
        foreach (v8[i]) begin
            run_op(8, v8[i].s, v8[i].a, v8[i].b, v8[i].c, rs, rc, ro, n, nb, hb, got);
            check($sformatf("w8_done_seen_%0d", i), got, 1);
            check($sformatf("w8_sum_%0d", i), rs, v8[i].es);
            check($sformatf("w8_cout_%0d", i), rc, v8[i].ec);
            check($sformatf("w8_ovf_%0d", i), ro, v8[i].eo);
            check($sformatf("w8_busy_cycles_%0d", i), nb, 8);
            check($sformatf("w8_done_latency_%0d", i), n, 9);
            check($sformatf("w8_sum_hold_%0d", i), hb, 0);
        end

        // ---------------- WIDTH=1 full-adder truth table ----------------
        v1[0] = mk(0, 0, 0, 0, 0, 0, 0);
        v1[1] = mk(0, 0, 0, 1, 1, 0, 1);
        v1[2] = mk(0, 0, 1, 0, 1, 0, 0);
        v1[3] = mk(0, 0, 1, 1, 0, 1, 0);
        v1[4] = mk(0, 1, 0, 0, 1, 0, 0);
        v1[5] = mk(0, 1, 0, 1, 0, 1, 0);
        v1[6] = mk(0, 1, 1, 0, 0, 1, 1);
        v1[7] = mk(0, 1, 1, 1, 1, 1, 0);
        foreach (v1[i]) begin
            run_op(1, v1[i].s, v1[i].a, v1[i].b, v1[i].c, rs, rc, ro, n, nb, hb, got);
            check($sformatf("w1_done_seen_%0d", i), got, 1);
            check($sformatf("w1_sum_%0d", i), rs, v1[i].es);
            check($sformatf("w1_cout_%0d", i), rc, v1[i].ec);
            check($sformatf("w1_ovf_%0d", i), ro, v1[i].eo);
            check($sformatf("w1_busy_cycles_%0d", i), nb, 1);
            check($sformatf("w1_done_latency_%0d", i), n, 2);
        end

        // ---------------- start pulsed mid-operation is ignored ----------------
        @(posedge clk); #1;
        drive(8, 1'b1, 1'b0, 16'h3C, 16'h5A, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'h00, 16'h00, 1'b0);
        nb = 1;
        for (int i = 0; i < 4 && nb < 3; i++) begin
            @(posedge clk); #1;
            if (busy8) nb++;
        end
        drive(8, 1'b1, 1'b1, 16'h11, 16'h22, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'h00, 16'h00, 1'b0);
        wait_done(8, 20, sum8, n, nb, hb, got);
        check("ign_done_seen", got, 1);
        check("ign_sum", sum8, 8'h96);
        check("ign_cout", cout8, 0);
        check("ign_ovf", ovf8, 1);
        @(posedge clk); #1;
        check("ign_idle_busy", busy8, 0);
        @(posedge clk); #1;
        check("ign_still_idle_busy", busy8, 0);
        check("ign_still_idle_done", done8, 0);

        // ---------------- start held through DONE is taken in IDLE ----------------
        @(posedge clk); #1;
        drive(8, 1'b1, 1'b0, 16'h3C, 16'h5A, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'h00, 16'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(8, 1'b1, 1'b0, 16'h7F, 16'h01, 1'b0);
        wait_done(8, 20, sum8, n, nb, hb, got);
        check("held_first_done_seen", got, 1);
        check("held_first_sum", sum8, 8'h96);
        @(posedge clk); #1;
        check("held_idle_busy", busy8, 0);
        @(posedge clk); #1;
        check("held_accept_busy", busy8, 1);
        drive(8, 1'b0, 1'b0, 16'h00, 16'h00, 1'b0);
        wait_done(8, 20, sum8, n, nb, hb, got);
        check("held_second_done_seen", got, 1);
        check("held_second_sum", sum8, 8'h80);
        check("held_second_cout", cout8, 0);
        check("held_second_ovf", ovf8, 1);

        // ---------------- reset during SHIFT aborts ----------------
        @(posedge clk); #1;
        drive(8, 1'b1, 1'b0, 16'hFF, 16'h01, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'h00, 16'h00, 1'b0);
        nb = 1;
        for (int i = 0; i < 6 && nb < 4; i++) begin
            @(posedge clk); #1;
            if (busy8) nb++;
        end
        check("abort_busy_before_rst", busy8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        check("abort_ovf", ovf8, 0);
        dseen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) dseen++;
        end
        check("abort_no_done_pulse", dseen, 0);

        // ---------------- WIDTH=16 randomised against a model ----------------
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb, bb;
            logic rsub, rcin, cc, emsb;
            logic [16:0] full;
            logic [15:0] low;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rsub = 1'($urandom);
            rcin = 1'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'h0001; rsub = 0; rcin = 1; end
            if (i == 1) begin ra = 16'h8000; rb = 16'h0001; rsub = 1; rcin = 0; end
            bb   = rsub ? ~rb : rb;
            cc   = rsub ? 1'b1 : rcin;
            full = {1'b0, ra} + {1'b0, bb} + 17'(cc);
            low  = {1'b0, ra[14:0]} + {1'b0, bb[14:0]} + 16'(cc);
            emsb = low[15];
            run_op(16, rsub, ra, rb, rcin, rs, rc, ro, n, nb, hb, got);
            check($sformatf("w16_done_seen_%0d", i), got, 1);
            check($sformatf("w16_sum_%0d", i), rs, full[15:0]);
            check($sformatf("w16_cout_%0d", i), rc, full[16]);
            check($sformatf("w16_ovf_%0d", i), ro, emsb ^ full[16]);
            if (!got) break;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
